// File: rtl/if_id_stage_reg.sv
// Fetch/Decode pipeline register: captures fetched bytes and joins opcode-12
// instructions with their immediate byte into one decode packet.
//
// state | meaning
// S_OP  | expecting an opcode byte
// S_IMM | first byte held, expecting the immediate/EA byte
module if_id_stage_reg #(
  parameter int         DATA_W      = 8,
  parameter int         PC_W        = 8,
  parameter logic [3:0] TWO_BYTE_OP = 4'd12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [PC_W-1:0]   pc_in,
  output logic [3:0]        opcode_out,
  output logic [1:0]        ra_out,
  output logic [1:0]        rb_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   pc_next_out,
  output logic              valid_out,
  output logic              imm_pending
);

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] hold_instr;
  logic [PC_W-1:0]   hold_pc;
  logic [PC_W-1:0]   pc_in_inc;

  assign pc_in_inc   = pc_in + PC_W'(1);
  assign imm_pending = (state == S_IMM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_OP;
      hold_instr  <= '0;
      hold_pc     <= '0;
      opcode_out  <= '0;
      ra_out      <= '0;
      rb_out      <= '0;
      imm_out     <= '0;
      pc_out      <= '0;
      pc_next_out <= '0;
      valid_out   <= 1'b0;
    end else if (flush) begin
      // PCs are kept so the redirect logic still sees the last packet's addresses
      state      <= S_OP;
      opcode_out <= '0;
      ra_out     <= '0;
      rb_out     <= '0;
      imm_out    <= '0;
      valid_out  <= 1'b0;
    end else if (!stall) begin
      case (state)
        S_OP: begin
          if (instr_in[7:4] == TWO_BYTE_OP) begin
            hold_instr <= instr_in;
            hold_pc    <= pc_in;
            valid_out  <= 1'b0;
            state      <= S_IMM;
          end else begin
            opcode_out  <= instr_in[7:4];
            ra_out      <= instr_in[3:2];
            rb_out      <= instr_in[1:0];
            imm_out     <= '0;
            pc_out      <= pc_in;
            pc_next_out <= pc_in_inc;
            valid_out   <= 1'b1;
          end
        end
        S_IMM: begin
          // Second byte is pure data, even if it looks like another opcode 12
          opcode_out  <= hold_instr[7:4];
          ra_out      <= hold_instr[3:2];
          rb_out      <= hold_instr[1:0];
          imm_out     <= instr_in;
          pc_out      <= hold_pc;
          pc_next_out <= pc_in_inc;
          valid_out   <= 1'b1;
          state       <= S_OP;
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg: hand-computed packets after each fetch edge.
module tb_if_id_stage_reg;

  logic       clk = 1'b0;
  logic       reset, stall, flush;
  logic [7:0] instr_in, pc_in;
  logic [3:0] opcode_out;
  logic [1:0] ra_out, rb_out;
  logic [7:0] imm_out, pc_out, pc_next_out;
  logic       valid_out, imm_pending;

  int errors = 0;
  int checks = 0;

  if_id_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .instr_in(instr_in), .pc_in(pc_in),
    .opcode_out(opcode_out), .ra_out(ra_out), .rb_out(rb_out),
    .imm_out(imm_out), .pc_out(pc_out), .pc_next_out(pc_next_out),
    .valid_out(valid_out), .imm_pending(imm_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one fetch cycle, then sample 1 time unit after the edge
  task automatic step(input logic [7:0] ins, input logic [7:0] pc,
                      input logic st, input logic fl, input logic rs);
    instr_in = ins;
    pc_in    = pc;
    stall    = st;
    flush    = fl;
    reset    = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pkt(input string tag, input logic [3:0] op, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] imm, input logic [7:0] pc,
                         input logic [7:0] pcn, input logic v, input logic ip);
    chk({tag, ".opcode"}, {12'd0, opcode_out}, {12'd0, op});
    chk({tag, ".ra"}, {14'd0, ra_out}, {14'd0, ra});
    chk({tag, ".rb"}, {14'd0, rb_out}, {14'd0, rb});
    chk({tag, ".imm"}, {8'd0, imm_out}, {8'd0, imm});
    chk({tag, ".pc"}, {8'd0, pc_out}, {8'd0, pc});
    chk({tag, ".pc_next"}, {8'd0, pc_next_out}, {8'd0, pcn});
    chk({tag, ".valid"}, {15'd0, valid_out}, {15'd0, v});
    chk({tag, ".imm_pending"}, {15'd0, imm_pending}, {15'd0, ip});
  endtask

  initial begin
    // Reset overrides a concurrent flush and an opcode byte
    step(8'h5B, 8'h10, 1'b0, 1'b1, 1'b1);
    step(8'h5B, 8'h10, 1'b0, 1'b0, 1'b1);
    chk_pkt("reset", 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // One-byte instructions back to back
    step(8'h5B, 8'h10, 1'b0, 1'b0, 1'b0);
    chk_pkt("one_a", 4'h5, 2'd2, 2'd3, 8'h00, 8'h10, 8'h11, 1'b1, 1'b0);
    step(8'h36, 8'h11, 1'b0, 1'b0, 1'b0);
    chk_pkt("one_b", 4'h3, 2'd1, 2'd2, 8'h00, 8'h11, 8'h12, 1'b1, 1'b0);

    // Two-byte instruction: bubble, then joined packet
    step(8'hC4, 8'h20, 1'b0, 1'b0, 1'b0);
    chk_pkt("two_bub", 4'h3, 2'd1, 2'd2, 8'h00, 8'h11, 8'h12, 1'b0, 1'b1);
    step(8'hAB, 8'h21, 1'b0, 1'b0, 1'b0);
    chk_pkt("two_pkt", 4'hC, 2'd1, 2'd0, 8'hAB, 8'h20, 8'h22, 1'b1, 1'b0);

    // Stall for 3 cycles between the bytes; stalled bytes must be ignored
    step(8'hC9, 8'h30, 1'b0, 1'b0, 1'b0);
    chk_pkt("stl_bub", 4'hC, 2'd1, 2'd0, 8'hAB, 8'h20, 8'h22, 1'b0, 1'b1);
    step(8'h11, 8'h31, 1'b1, 1'b0, 1'b0);
    chk_pkt("stl_1", 4'hC, 2'd1, 2'd0, 8'hAB, 8'h20, 8'h22, 1'b0, 1'b1);
    step(8'h22, 8'h31, 1'b1, 1'b0, 1'b0);
    chk_pkt("stl_2", 4'hC, 2'd1, 2'd0, 8'hAB, 8'h20, 8'h22, 1'b0, 1'b1);
    step(8'h33, 8'h31, 1'b1, 1'b0, 1'b0);
    chk_pkt("stl_3", 4'hC, 2'd1, 2'd0, 8'hAB, 8'h20, 8'h22, 1'b0, 1'b1);
    step(8'h5E, 8'h31, 1'b0, 1'b0, 1'b0);
    chk_pkt("stl_pkt", 4'hC, 2'd2, 2'd1, 8'h5E, 8'h30, 8'h32, 1'b1, 1'b0);
    // Stall holds a valid packet too
    step(8'h44, 8'h32, 1'b1, 1'b0, 1'b0);
    chk_pkt("stl_hold", 4'hC, 2'd2, 2'd1, 8'h5E, 8'h30, 8'h32, 1'b1, 1'b0);

    // Flush + stall in S_IMM: flush wins, partial instruction dropped
    step(8'hC4, 8'h40, 1'b0, 1'b0, 1'b0);
    chk("fl_pend", {15'd0, imm_pending}, 16'd1);
    step(8'h77, 8'h41, 1'b1, 1'b1, 1'b0);
    chk_pkt("flush", 4'h0, 2'd0, 2'd0, 8'h00, 8'h30, 8'h32, 1'b0, 1'b0);
    step(8'h5B, 8'h42, 1'b0, 1'b0, 1'b0);
    chk_pkt("fl_after", 4'h5, 2'd2, 2'd3, 8'h00, 8'h42, 8'h43, 1'b1, 1'b0);

    // Immediate byte whose top nibble is the two-byte opcode is still data
    step(8'hC0, 8'h50, 1'b0, 1'b0, 1'b0);
    step(8'hC7, 8'h51, 1'b0, 1'b0, 1'b0);
    chk_pkt("imm_c", 4'hC, 2'd0, 2'd0, 8'hC7, 8'h50, 8'h52, 1'b1, 1'b0);

    // PC wrap
    step(8'h70, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk_pkt("wrap", 4'h7, 2'd0, 2'd0, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);

    // Reset during S_IMM, then no partial packet afterwards
    step(8'hC0, 8'h60, 1'b0, 1'b0, 1'b0);
    chk("rs_pend", {15'd0, imm_pending}, 16'd1);
    step(8'h12, 8'h61, 1'b0, 1'b0, 1'b1);
    chk_pkt("rs_imm", 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(8'h34, 8'h62, 1'b0, 1'b0, 1'b0);
    chk_pkt("rs_after", 4'h3, 2'd1, 2'd0, 8'h00, 8'h62, 8'h63, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
- Pipeline register between the Fetch stage and the Decode stage.
- Captures each byte fetched from instruction memory along with its PC.
- Joins two-byte instructions (opcode 12: LDM/LDD/STD) into one decoded packet: opcode byte plus immediate/EA byte.
- Applies the stall and flush requests from the fetch control unit, and inserts bubbles during branch redirect, interrupt entry and immediate collection.

Parameters:
- DATA_W, 8, width of an instruction-memory word and of the immediate.
- PC_W, 8, width of the program counter.
- TWO_BYTE_OP, 4'd12, opcode value that marks an instruction carrying a second (immediate) byte.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- stall  input  1  hold request from the fetch CU or hazard logic; freeze all registers.
- flush  input  1  discard request (taken branch, jump, RET/RTI load, interrupt entry); has priority over stall.
- instr_in  input  DATA_W  byte read from instruction memory this cycle.
- pc_in  input  PC_W  address of instr_in.
- opcode_out  output  4  latched instr[7:4].
- ra_out  output  2  latched instr[3:2], which is also the brx field.
- rb_out  output  2  latched instr[1:0].
- imm_out  output  DATA_W  latched second byte; 0 for one-byte instructions.
- pc_out  output  PC_W  PC of the opcode byte of the latched instruction.
- pc_next_out  output  PC_W  PC following the last byte of the instruction, computed mod 2^PC_W; used as the CALL/interrupt return address.
- valid_out  output  1  decode packet is a real instruction; 0 means bubble/NOP.
- imm_pending  output  1  high while the block is in S_IMM, waiting for the second byte.

Behaviour:
- Reset:
  - All outputs become 0; state becomes S_OP.
  - Internal hold registers (first byte, first PC) are cleared.
  - Reset overrides flush and stall.
- Priority per rising edge: reset > flush > stall > normal capture.
- States:
  - S_OP: expecting an opcode byte.
  - S_IMM: expecting an immediate byte; the first byte is already held internally.
- flush, in either state:
  - opcode/ra/rb/imm cleared to 0, valid_out=0, state becomes S_OP.
  - A partially collected two-byte instruction is dropped.
  - pc_out and pc_next_out are unchanged.
- stall, no flush:
  - Every register, including the state and the hold registers, keeps its value.
  - instr_in is ignored.
- S_OP, instr_in[7:4] != TWO_BYTE_OP:
  - Latch opcode/ra/rb from instr_in; imm_out=0.
  - pc_out=pc_in; pc_next_out=pc_in+1.
  - valid_out=1; stay in S_OP.
- S_OP, instr_in[7:4] == TWO_BYTE_OP:
  - Store instr_in and pc_in in the hold registers.
  - valid_out=0 (bubble); other outputs keep their values.
  - Go to S_IMM.
- S_IMM:
  - opcode/ra/rb come from the held byte; imm_out=instr_in.
  - pc_out=held PC; pc_next_out=pc_in+1.
  - valid_out=1; go to S_OP.
  - instr_in is taken as data even if its top nibble equals TWO_BYTE_OP.
- Latency:
  - One-byte instruction: visible on the outputs 1 cycle after its fetch edge.
  - Two-byte instruction: visible 1 cycle after the immediate byte's fetch edge; 2 cycles after the opcode fetch if there is no stall.
- valid_out is a registered output. It is high for exactly one cycle per captured instruction unless stall holds it.
- imm_pending is decoded from the state register (registered, glitch-free).
- PC wrap: pc_in = 2^PC_W-1 gives pc_next_out = 0.
- Reset asserted while in S_IMM: the next state is S_OP with all outputs 0; no partial instruction is emitted later.
- stall and flush asserted in the same cycle: flush wins.

Test Plan:
1. Reset, then feed bytes 0x5B, 0x36 at pc 0x10, 0x11 with no stall -> cycle 1: opcode=5, ra=2, rb=3, valid=1, pc_out=0x10, pc_next_out=0x11. Cycle 2: opcode=3, ra=1, rb=2, pc_out=0x11.
2. Feed 0xC4 at pc 0x20, then 0xAB at pc 0x21 -> cycle 1: valid=0, imm_pending=1. Cycle 2: opcode=12, ra=1, rb=0, imm=0xAB, pc_out=0x20, pc_next_out=0x22, valid=1, imm_pending=0.
3. Two-byte instruction with stall=1 for 3 cycles between its bytes -> state and outputs frozen, imm_pending stays 1. After stall drops, the packet emits with imm equal to the byte present on the first unstalled edge.
4. In S_IMM assert flush+stall together -> next cycle valid=0, opcode=0, imm_pending=0. Following byte 0x5B decodes as a one-byte instruction.
5. pc_in=0xFF with byte 0x70 -> pc_next_out=0x00. Then assert reset during S_IMM of a 0xC0 instruction -> all outputs 0 and state S_OP on the next edge.
